// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver.
//   GLYPH     : 16-entry active-low segment patterns {g..a} for hex 0..F
//   SEG_BLANK : full segment byte {dp,g..a} with everything dark
//   AN_OFF    : level of one anode select bit when its digit is not driven
package seg_pkg;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h18, 7'h08, 7'h03,   // 8 9 A B
        7'h46, 7'h21, 7'h06, 7'h0E    // C D E F
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic       AN_OFF    = 1'b1;

    typedef enum logic {
        BLINK_SHOW = 1'b0,
        BLINK_HIDE = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder.
//   nib   : 4-bit hex value
//   glyph : active-low segments {g,f,e,d,c,b,a}
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH[nib];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for N_DIGITS common-anode seven-segment digits.
//   clk, rst_n  : clock, asynchronous active-low reset
//   halt        : freeze the displayed value (scanning keeps running)
//   num         : hex value, nibble i -> digit i
//   dp          : per-digit decimal point enable (1 = lit)
//   blink_mask  : per-digit blink enable
//   blank_lz    : suppress leading zeros (digit 0 always shown)
//   an          : active-low digit select, at most one bit low
//   seg         : active-low segments {dp,g..a}
//   frame_done  : one-cycle pulse after each completed scan frame
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned CLK_DIV      = 10000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  halt,
    input  logic [4*N_DIGITS-1:0] num,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  blank_lz,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int unsigned IW = $clog2(N_DIGITS);
    localparam int unsigned PW = $clog2(CLK_DIV) + 1;
    localparam int unsigned BW = $clog2(BLINK_FRAMES) + 1;

    logic [PW-1:0]         pre_cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] snap;
    logic [BW-1:0]         blink_cnt;
    blink_phase_t          phase;
    logic                  upd;
    logic                  tick;
    logic                  wrap;

    logic [3:0]            nib;
    logic [6:0]            glyph;
    logic                  upper_nz;
    logic                  blank;
    logic [N_DIGITS-1:0]   an_next;
    logic [7:0]            seg_next;

    assign tick = (pre_cnt == PW'(CLK_DIV - 1));
    assign wrap = tick && (idx == IW'(N_DIGITS - 1));

    seg_hex_decode u_dec (
        .nib   (nib),
        .glyph (glyph)
    );

    always_comb begin
        nib      = snap[{idx, 2'b00} +: 4];
        upper_nz = 1'b0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (k >= 32'(idx) && snap[k*4 +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        blank = (blink_mask[idx] && phase == BLINK_HIDE) ||
                (blank_lz && idx != '0 && !upper_nz);

        an_next  = {N_DIGITS{AN_OFF}};
        seg_next = SEG_BLANK;
        if (!blank) begin
            for (int unsigned k = 0; k < N_DIGITS; k++) begin
                if (k == 32'(idx)) begin
                    an_next[k] = ~AN_OFF;
                end
            end
            seg_next = {~dp[idx], glyph};
        end
    end

    // The display register loads only in the cycle after a tick, i.e. while the
    // index is freshly updated, so an/seg stay dark until the first tick after
    // reset and each digit appears exactly one cycle after its index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            idx        <= '0;
            snap       <= '0;
            blink_cnt  <= '0;
            phase      <= BLINK_SHOW;
            upd        <= 1'b0;
            frame_done <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
        end else begin
            pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
            upd        <= tick;
            frame_done <= wrap;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            if (wrap) begin
                if (!halt) begin
                    snap <= num;
                end
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    phase     <= (phase == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            if (upd) begin
                an  <= an_next;
                seg <= seg_next;
            end
        end
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed digits; legal range 2..16.
REQ-002 Parameter CLK_DIV, default 10000: clk cycles per digit slot; legal range >=1.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period; legal range >=1.
REQ-004 clk  input  1  system clock; all state on rising edge; single clock domain.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 halt  input  1  1 = freeze displayed value; scanning continues.
REQ-007 num  input  4*N_DIGITS  hex value; nibble i drives digit i, with nibble 0 at bits [3:0].
REQ-008 dp  input  N_DIGITS  per-digit decimal point enable, 1 = lit.
REQ-009 blink_mask  input  N_DIGITS  1 = digit blinks.
REQ-010 blank_lz  input  1  1 = suppress leading zeros.
REQ-011 an  output  N_DIGITS  digit select, active-low, one-hot-zero.
REQ-012 seg  output  8  segments {dp,g..a}, active-low.
REQ-013 frame_done  output  1  one-cycle pulse per completed scan frame.

Function
REQ-014 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be 1 in the cycle where count = CLK_DIV-1; CLK_DIV=1 SHALL tick every cycle.
REQ-015 Digit index SHALL advance by 1 on each tick and wrap from N_DIGITS-1 to 0.
REQ-016 On the tick where the index wraps to 0, frame_done SHALL be 1 for exactly the following cycle.
REQ-017 Snapshot register SHALL load num on each wrap tick when halt=0; it SHALL hold when halt=1; halt SHALL NOT stop the prescaler, index or frame_done.
REQ-018 Display SHALL use only the snapshot, never live num; dp, blink_mask and blank_lz SHALL be sampled live.
REQ-019 Blink frame counter SHALL count frames 0..BLINK_FRAMES-1; on wrap, blink phase SHALL toggle.
REQ-020 Digit i SHALL be blanked when blink_mask[i]=1 and phase=1.
REQ-021 Digit i (i>0) SHALL be blanked when blank_lz=1 and snapshot nibbles i..N_DIGITS-1 are all zero; digit 0 SHALL never be lz-blanked.
REQ-022 Blanked digit: an SHALL be all ones and seg SHALL be 8'hFF, including dp.
REQ-023 Unblanked digit i: an[i]=0, all other an bits 1; seg[6:0] = hex-decoded glyph of nibble i; seg[7] = ~dp[i].
REQ-024 an and seg SHALL be registered; they SHALL reflect a new index exactly one cycle after the index register changes.
REQ-025 The glyph table SHALL be 0..F standard active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98, A=88, B=83, C=C6, D=A1, E=86, F=8E (seg[7]=1).

Reset
REQ-026 While rst_n=0: prescaler=0, index=0, snapshot=0, blink counter=0, phase=0, an=all ones, seg=8'hFF, frame_done=0.
REQ-027 Reset asserted mid-frame SHALL apply immediately, without a clock edge; the first post-reset frame SHALL display snapshot zero.

Structure
REQ-028 Package seg_pkg SHALL hold the 16-entry glyph constants, SEG_BLANK=8'hFF and AN_OFF.
REQ-029 Combinational sub-module seg_hex_decode (4-bit in, 7-bit out) SHALL implement REQ-025; all other logic SHALL be in seg_scan_driver.
REQ-030 Index width SHALL be clog2(N_DIGITS); prescaler width SHALL be clog2(CLK_DIV)+1.

Verification (bench: N_DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2)
REQ-031 Set num=16'h12AF, dp=0, halt=0, then run 2 frames -> an cycles 1110, 1101, 1011, 0111 every 4 clk; seg sequence 8E, 88, A4, F9; frame_done pulses every 16 clk.
REQ-032 Set halt=1 after a 16'h12AF frame and change num to 16'h0000 -> display stays 12AF; set halt=0 -> 0000 appears from the next frame start.
REQ-033 Set num=16'h0005 with blank_lz=1 -> digits 3..1 show an=1111/seg=FF; digit 0 shows 92; num=0 shows digit 0 as C0 only.
REQ-034 Set blink_mask=4'b0001 and dp=4'b0010 -> digit 0 is blanked in alternate 2-frame periods; digit 1 seg[7]=0 throughout.
REQ-035 Assert rst_n=0 at mid-slot on index 2 -> outputs go to reset values with no clock edge; after release, first tick selects digit 1, and an=1111 before it.
REQ-036 Set CLK_DIV=1 -> digit advances every clock and frame_done has period N_DIGITS.
